// File: rtl/mux_nto1_reg_if.sv
// Bus bundle for the registered N-to-1 multiplexer: producer inputs,
// selection controls and the single registered output.
//
// Handshake: a word moves across a channel at a rising clock edge when its
// valid and ready are both high. A producer holds data and valid stable while
// valid is high and ready is low; ready may depend combinationally on valid.
interface mux_nto1_reg_if #(
   parameter int WIDTH     = 32,
   parameter int NUM_IN    = 3,
   parameter int SEL_WIDTH = 2
);
   logic [NUM_IN*WIDTH-1:0] In;
   logic [NUM_IN-1:0]       InValid;
   logic [NUM_IN-1:0]       InReady;
   logic [1:0]              Mode;
   logic [SEL_WIDTH-1:0]    Select;
   logic [WIDTH-1:0]        Out;
   logic                    OutValid;
   logic                    OutReady;
   logic [SEL_WIDTH-1:0]    OutSrc;

   // Environment side: producers, mode control and the consumer.
   modport master (
      output In, InValid, Mode, Select, OutReady,
      input  InReady, Out, OutValid, OutSrc
   );

   // Multiplexer side.
   modport slave (
      input  In, InValid, Mode, Select, OutReady,
      output InReady, Out, OutValid, OutSrc
   );
endinterface

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 multiplexer with per-input valid/ready and one output
// register. Selection modes: 00 explicit select (saturating), 01/11 fixed
// priority (lowest index wins), 10 round-robin starting after the last
// round-robin winner.
module mux_nto1_reg #(
   parameter int WIDTH     = 32,
   parameter int NUM_IN    = 3,
   parameter int SEL_WIDTH = 2
) (
   input logic             Clock,
   input logic             Reset_n,
   mux_nto1_reg_if.slave   bus
);

   localparam logic [SEL_WIDTH:0]   LP_NUM_IN = (SEL_WIDTH+1)'(NUM_IN);
   localparam logic [SEL_WIDTH-1:0] LP_LAST   = SEL_WIDTH'(NUM_IN-1);

   logic [WIDTH-1:0]     r_out;
   logic                 r_out_valid;
   logic [SEL_WIDTH-1:0] r_out_src;
   logic [SEL_WIDTH-1:0] r_rr_last;

   logic [NUM_IN-1:0]    w_grant;
   logic [SEL_WIDTH-1:0] w_idx;
   logic                 w_found;
   logic                 w_load_en;
   logic                 w_xfer;
   logic [WIDTH-1:0]     w_data;

   // The register can take a new word whenever it is empty or being drained
   // this cycle, so a full stream moves one word per clock.
   assign w_load_en = ~r_out_valid | bus.OutReady;

   // Grant selection: one index per cycle, depending on the mode.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      case (bus.Mode)
         2'b00: begin
            // Explicit select grants even without valid; out-of-range
            // indices saturate to the top input.
            w_found = 1'b1;
            if ({1'b0, bus.Select} >= LP_NUM_IN) begin
               w_idx = LP_LAST;
            end else begin
               w_idx = bus.Select;
            end
         end
         2'b10: begin
            // Search starts one past the last round-robin winner.
            for (int k = 1; k <= NUM_IN; k++) begin
               if (!w_found && bus.InValid[(int'(r_rr_last) + k) % NUM_IN]) begin
                  w_found = 1'b1;
                  w_idx   = SEL_WIDTH'((int'(r_rr_last) + k) % NUM_IN);
               end
            end
         end
         default: begin
            // Walk downward so the lowest valid index is the last written.
            for (int i = NUM_IN - 1; i >= 0; i--) begin
               if (bus.InValid[i]) begin
                  w_found = 1'b1;
                  w_idx   = SEL_WIDTH'(i);
               end
            end
         end
      endcase
      if (w_found) begin
         w_grant[w_idx] = 1'b1;
      end
   end

   // Ready is withheld while reset is asserted and while the output stalls.
   assign bus.InReady = w_grant & {NUM_IN{w_load_en & Reset_n}};
   assign w_xfer      = |(bus.InValid & bus.InReady);
   assign w_data      = bus.In[int'(w_idx)*WIDTH +: WIDTH];

   // Output register, source tag and round-robin pointer.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_out_src   <= '0;
         r_rr_last   <= LP_LAST;
      end else if (w_xfer) begin
         r_out       <= w_data;
         r_out_src   <= w_idx;
         r_out_valid <= 1'b1;
         if (bus.Mode == 2'b10) begin
            r_rr_last <= w_idx;
         end
      end else if (bus.OutReady) begin
         // Consumed with nothing new: data and source stay for inspection.
         r_out_valid <= 1'b0;
      end
   end

   assign bus.Out      = r_out;
   assign bus.OutValid = r_out_valid;
   assign bus.OutSrc   = r_out_src;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg with NUM_IN=3, WIDTH=32: vector table plus
// hand-written sequences for stall, drain and mid-stream reset.
module tb_mux_nto1_reg;

   localparam int W = 34;

   typedef struct {
      logic [1:0] mode;
      logic [1:0] sel;
      logic [2:0] valid;
      logic       out_ready;
      logic [2:0] exp_ready;
      logic       exp_ov;
   } vec_t;

   logic clk;
   logic rst_n;

   mux_nto1_reg_if #(.WIDTH(32), .NUM_IN(3), .SEL_WIDTH(2)) bus ();

   mux_nto1_reg #(.WIDTH(32), .NUM_IN(3), .SEL_WIDTH(2)) dut (
      .Clock   (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0]  exp_q[$];
   logic [31:0]   in_w[3];
   logic [31:0]   hold_out;
   logic [1:0]    hold_src;
   int            n_pass;
   int            n_total;
   vec_t          tbl[21];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Drives one cycle (entered #1 after a rising edge), checks ready mid-cycle,
   // then checks the registered result #1 after the next rising edge.
   task automatic run_vec(input string tag, input vec_t v);
      logic [2:0]   acc;
      logic         pushed;
      logic [W-1:0] e;
      bus.Mode     = v.mode;
      bus.Select   = v.sel;
      bus.InValid  = v.valid;
      bus.OutReady = v.out_ready;
      bus.In       = {in_w[2], in_w[1], in_w[0]};
      #3;
      check({tag, " in_ready"}, 64'(bus.InReady), 64'(v.exp_ready));
      acc    = v.exp_ready & v.valid;
      pushed = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) begin
            exp_q.push_back({2'(i), in_w[i]});
            pushed = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check({tag, " out_valid"}, 64'(bus.OutValid), 64'(v.exp_ov));
      if (pushed) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
         end else begin
            e        = exp_q.pop_front();
            hold_src = e[33:32];
            hold_out = e[31:0];
         end
      end
      check({tag, " out"}, 64'(bus.Out), 64'(hold_out));
      check({tag, " out_src"}, 64'(bus.OutSrc), 64'(hold_src));
   endtask

   task automatic rand_data();
      for (int i = 0; i < 3; i++) in_w[i] = $urandom_range(32'hFFFF_FFFF, 0);
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      hold_out = '0;
      hold_src = '0;
      for (int i = 0; i < 3; i++) in_w[i] = '0;
      bus.In       = '0;
      bus.InValid  = 3'b111;
      bus.Mode     = 2'b01;
      bus.Select   = '0;
      bus.OutReady = 1'b1;

      // mode, sel, valid, out_ready, exp_ready, exp_ov
      tbl[0]  = '{2'b10, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1};
      tbl[1]  = '{2'b10, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1};
      tbl[2]  = '{2'b10, 2'd0, 3'b111, 1'b1, 3'b100, 1'b1};
      tbl[3]  = '{2'b10, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1};
      tbl[4]  = '{2'b10, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1};
      tbl[5]  = '{2'b10, 2'd0, 3'b111, 1'b1, 3'b100, 1'b1};
      tbl[6]  = '{2'b00, 2'd1, 3'b111, 1'b1, 3'b010, 1'b1};
      tbl[7]  = '{2'b00, 2'd3, 3'b111, 1'b1, 3'b100, 1'b1};
      tbl[8]  = '{2'b00, 2'd3, 3'b011, 1'b1, 3'b100, 1'b0};
      tbl[9]  = '{2'b01, 2'd0, 3'b110, 1'b1, 3'b010, 1'b1};
      tbl[10] = '{2'b01, 2'd0, 3'b100, 1'b1, 3'b100, 1'b1};
      tbl[11] = '{2'b11, 2'd0, 3'b011, 1'b1, 3'b001, 1'b1};
      tbl[12] = '{2'b10, 2'd0, 3'b110, 1'b1, 3'b010, 1'b1};
      tbl[13] = '{2'b10, 2'd0, 3'b011, 1'b0, 3'b000, 1'b1};
      tbl[14] = '{2'b10, 2'd0, 3'b011, 1'b0, 3'b000, 1'b1};
      tbl[15] = '{2'b10, 2'd0, 3'b011, 1'b1, 3'b001, 1'b1};
      tbl[16] = '{2'b10, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0};
      tbl[17] = '{2'b10, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0};
      tbl[18] = '{2'b10, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0};
      tbl[19] = '{2'b01, 2'd0, 3'b001, 1'b0, 3'b001, 1'b1};
      tbl[20] = '{2'b01, 2'd0, 3'b001, 1'b0, 3'b000, 1'b1};

      // reset
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("por out", 64'(bus.Out), 64'h0);
      check("por out_valid", 64'(bus.OutValid), 64'h0);
      check("por out_src", 64'(bus.OutSrc), 64'h0);
      check("por in_ready", 64'(bus.InReady), 64'h0);
      rst_n = 1'b1;

      // vector table
      for (int i = 0; i < 21; i++) begin
         if (tbl[i].exp_ready != 3'b000 || tbl[i].exp_ov == 1'b0) rand_data();
         run_vec($sformatf("vec%0d", i), tbl[i]);
      end

      // mid-stream reset while a word is held
      bus.Mode     = 2'b01;
      bus.InValid  = 3'b111;
      bus.OutReady = 1'b1;
      rst_n        = 1'b0;
      #2;
      check("mid_rst out", 64'(bus.Out), 64'h0);
      check("mid_rst out_valid", 64'(bus.OutValid), 64'h0);
      check("mid_rst out_src", 64'(bus.OutSrc), 64'h0);
      check("mid_rst in_ready", 64'(bus.InReady), 64'h0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      hold_out = '0;
      hold_src = '0;
      exp_q.delete();
      rand_data();
      run_vec("rr_after_rst", '{2'b10, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1});

      // explicit select with a known word, then four stalled cycles
      in_w[0] = 32'h0000_0000;
      in_w[1] = 32'hA5A5_0001;
      in_w[2] = 32'h0000_0002;
      run_vec("sel1", '{2'b00, 2'd1, 3'b111, 1'b1, 3'b010, 1'b1});
      for (int i = 0; i < 4; i++) begin
         run_vec($sformatf("stall%0d", i), '{2'b00, 2'd1, 3'b111, 1'b0, 3'b000, 1'b1});
      end

      // release with new words: consume and load together, then drain
      in_w[1] = 32'h11;
      in_w[2] = 32'h22;
      run_vec("prio1", '{2'b01, 2'd0, 3'b110, 1'b1, 3'b010, 1'b1});
      run_vec("prio2", '{2'b01, 2'd0, 3'b100, 1'b1, 3'b100, 1'b1});
      run_vec("drain0", '{2'b01, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0});
      run_vec("drain1", '{2'b01, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0});

      check("queue_empty", 64'(exp_q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
